// File: rtl/button_stepper.sv
// Push-button front end: 2-FF synchronizer, debouncer and press/hold/auto-repeat FSM
// that emits single-cycle step pulses. Auto-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
module button_stepper #(
  parameter int CNT_W           = 24,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int HOLD_CYCLES     = 13500000,
  parameter int REPEAT_CYCLES   = 2700000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic step,
  output logic pressed,
  output logic repeating
);

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_stepper: cycle parameters out of range");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
`else
  typedef enum logic {IDLE, HOLD} state_t;
`endif

  state_t           state, state_nxt;
  logic             sync1, sync2;
  logic             raw_pressed;
  logic [CNT_W-1:0] deb_cnt;
  logic             deb_flip;
  logic             pressed_nxt;
  logic             step_nxt;

  assign raw_pressed = ~sync2;
  // The FSM reacts to the debounced level that takes effect at this same edge.
  assign deb_flip    = (raw_pressed != pressed) && (deb_cnt == DEB_LAST);
  assign pressed_nxt = pressed ^ deb_flip;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      pressed <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      if (raw_pressed == pressed) begin
        deb_cnt <= '0;
      end else if (deb_flip) begin
        pressed <= ~pressed;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  logic [CNT_W-1:0] hr_cnt, hr_cnt_nxt;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    step_nxt   = 1'b0;
    hr_cnt_nxt = hr_cnt;
    case (state)
      IDLE: begin
        if (pressed_nxt && !pressed) begin
          step_nxt   = 1'b1;
          hr_cnt_nxt = '0;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (!pressed_nxt) begin
          hr_cnt_nxt = '0;
          state_nxt  = IDLE;
        end else if (hr_cnt == HOLD_LAST) begin
          step_nxt   = 1'b1;
          hr_cnt_nxt = '0;
          state_nxt  = REPEAT;
        end else begin
          hr_cnt_nxt = hr_cnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!pressed_nxt) begin
          hr_cnt_nxt = '0;
          state_nxt  = IDLE;
        end else if (hr_cnt == REP_LAST) begin
          step_nxt   = 1'b1;
          hr_cnt_nxt = '0;
        end else begin
          hr_cnt_nxt = hr_cnt + CNT_W'(1);
        end
      end
      default: begin
        hr_cnt_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hr_cnt    <= '0;
      step      <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state     <= state_nxt;
      hr_cnt    <= hr_cnt_nxt;
      step      <= step_nxt;
      repeating <= (state_nxt == REPEAT);
    end
  end
`else
  // Single step per press: HOLD only waits for release.
  always_comb begin
    state_nxt = state;
    step_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (pressed_nxt && !pressed) begin
          step_nxt  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!pressed_nxt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  assign repeating = 1'b0;
`endif

endmodule
